// File: rtl/led_btn_ctrl.sv
// Button-to-LED panel controller: per-channel sync, debounce, press detect and LED mode.
// Optional PWM dimming is compiled in when LED_PWM_DIM_EN is defined.
module led_btn_ctrl #(
    parameter int NUM_CH         = 5,
    parameter int DEBOUNCE_CYC   = 1_562_500,
    parameter int BLINK_HALF_CYC = 39_062_500,
    parameter int PWM_BITS       = 4
) (
    input  logic                  clk156,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     user_btn,
    input  logic [2*NUM_CH-1:0]   mode,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0]   dim_level,
`endif
    output logic [NUM_CH-1:0]     user_led,
    output logic [NUM_CH-1:0]     press_evt
);

    localparam int DCW = $clog2(DEBOUNCE_CYC);
    localparam int BW  = $clog2(BLINK_HALF_CYC);
    localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF_CYC - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    if (DEBOUNCE_CYC < 2 || BLINK_HALF_CYC < 2 || PWM_BITS < 1) begin : g_bad_params
        $error("led_btn_ctrl: DEBOUNCE_CYC and BLINK_HALF_CYC must be >= 2, PWM_BITS >= 1");
    end

    logic [NUM_CH-1:0]   sync1, sync2, stable, stable_d, latch;
    logic [DCW-1:0]      db_cnt [NUM_CH];
    logic [2*NUM_CH-1:0] mode_q;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;

    logic                blink_wrap, blink_phase_next;
    logic [NUM_CH-1:0]   press, latch_next, led_state, led_gate;

    // Latch and LED decisions use next-state values so the LED lands on the same edge as press_evt.
    always_comb begin
        press            = stable & ~stable_d;
        blink_wrap       = (blink_cnt == BLINK_LAST);
        blink_phase_next = blink_phase ^ blink_wrap;
        latch_next       = latch;
        led_state        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode[2*i +: 2] != mode_q[2*i +: 2]) begin
                latch_next[i] = 1'b0;
            end else begin
                case (mode_t'(mode[2*i +: 2]))
                    MODE_TOGGLE, MODE_BLINK: latch_next[i] = latch[i] ^ press[i];
                    default:                 latch_next[i] = 1'b0;
                endcase
            end
            case (mode_t'(mode[2*i +: 2]))
                MODE_DIRECT: led_state[i] = stable[i];
                MODE_TOGGLE: led_state[i] = latch_next[i];
                MODE_BLINK:  led_state[i] = latch_next[i] & blink_phase_next;
                default:     led_state[i] = 1'b0;
            endcase
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt, pwm_next;

    always_comb begin
        pwm_next = pwm_cnt + PWM_BITS'(1);
        if (dim_level == '1) begin
            led_gate = '1;
        end else if (pwm_next < dim_level) begin
            led_gate = '1;
        end else begin
            led_gate = '0;
        end
    end

    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_next;
        end
    end
`else
    assign led_gate = '1;
`endif

    // A bounce anywhere inside the window restarts that channel's count.
    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            stable_d    <= '0;
            latch       <= '0;
            mode_q      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            press_evt   <= '0;
            user_led    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= user_btn;
            sync2 <= sync1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DCW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            stable_d    <= stable;
            latch       <= latch_next;
            mode_q      <= mode;
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink_phase <= blink_phase_next;
            press_evt   <= press;
            user_led    <= led_state & led_gate;
        end
    end

endmodule
